// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry (main + skid) pipeline register with a registered
// ready path, stage control (advance / hold / flush) and optional statistics.
// Optional feature macro: PIPE_SKID_STAT_EN enables the saturating
// stat_backpressure and stat_flush_drop counters. Without it the stat ports
// are tied to zero and no counter flops exist.
//
// Stall encodings:
//   STALL_NEXT = 2'b00  normal operation
//   STALL_KEEP = 2'b01  freeze, handshakes masked
//   STALL_ZERO = 2'b10  flush (2'b11 is undefined and also flushes)
module pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stat_backpressure,
  output logic [CNT_W-1:0]  stat_flush_drop
);

  localparam logic [1:0] STALL_NEXT = 2'b00;
  localparam logic [1:0] STALL_KEEP = 2'b01;
  localparam logic [1:0] STALL_ZERO = 2'b10;

  logic              r_main_vld;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_vld;
  logic [DATA_W-1:0] r_skid_data;

  logic w_next;
  logic w_keep;
  logic w_flush;
  logic w_accept;
  logic w_send;

  assign w_next  = (stall == STALL_NEXT);
  assign w_keep  = (stall == STALL_KEEP);
  // Any encoding other than NEXT/KEEP is treated as a flush.
  assign w_flush = (stall == STALL_ZERO) || (!w_next && !w_keep);

  // Ready depends only on registered skid state and stall, never on out_ready.
  assign in_ready  = !r_skid_vld && !w_keep;
  assign out_valid = r_main_vld && !w_keep;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

  assign w_accept = in_valid && in_ready;
  assign w_send   = out_valid && out_ready;

  // Main/skid entry update: reset and flush clear, NEXT advances, KEEP holds.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_main_vld  <= 1'b0;
      r_main_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
    end else if (w_next) begin
      if (!r_main_vld) begin
        // Empty: the accepted word lands in main and shows next cycle.
        if (w_accept) begin
          r_main_vld  <= 1'b1;
          r_main_data <= in_data;
        end
      end else begin
        case ({w_accept, w_send})
          2'b11: begin
            // Skid is empty whenever accept is possible, so main just refills.
            r_main_data <= in_data;
          end
          2'b10: begin
            r_skid_vld  <= 1'b1;
            r_skid_data <= in_data;
          end
          2'b01: begin
            if (r_skid_vld) begin
              r_main_data <= r_skid_data;
              r_skid_vld  <= 1'b0;
            end else begin
              r_main_vld <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef PIPE_SKID_STAT_EN
  logic [CNT_W-1:0] r_stat_bp;
  logic [CNT_W-1:0] r_stat_fd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Saturating statistics: downstream backpressure and payloads lost to flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_bp <= '0;
      r_stat_fd <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        r_stat_bp <= sat_inc(r_stat_bp);
      end
      if (w_flush && ((occupancy != 2'd0) || w_accept)) begin
        r_stat_fd <= sat_inc(r_stat_fd);
      end
    end
  end

  assign stat_backpressure = r_stat_bp;
  assign stat_flush_drop   = r_stat_fd;
`else
  assign stat_backpressure = '0;
  assign stat_flush_drop   = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, reset and
// randomised-handshake sequences against a queue scoreboard.
module tb_pipe_skid_reg;

  localparam int DW = 16;
  localparam int CW = 32;
  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] SK = 2'b01;
  localparam logic [1:0] SZ = 2'b10;
  localparam logic [1:0] SU = 2'b11;
`ifdef PIPE_SKID_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    stall;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stat_backpressure;
  logic [CW-1:0] stat_flush_drop;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .occupancy         (occupancy),
    .stat_backpressure (stat_backpressure),
    .stat_flush_drop   (stat_flush_drop)
  );

  typedef struct {
    logic [1:0]    stall;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_irdy;
    logic          e_ovld;
    logic [DW-1:0] e_odata;
    logic [1:0]    e_occ;
    int            e_bp;
    int            e_fd;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] stat_exp(input int v);
    return STAT_EN ? 64'(v) : 64'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = SN; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic iv, input logic [DW-1:0] id,
                              input logic ordy, input logic eir, input logic eov,
                              input logic [DW-1:0] eod, input logic [1:0] eocc,
                              input int ebp, input int efd);
    vec_t v;
    v.stall = s; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_irdy = eir; v.e_ovld = eov; v.e_odata = eod; v.e_occ = eocc;
    v.e_bp = ebp; v.e_fd = efd;
    return v;
  endfunction

  initial begin
    int   rand_err;
    int   bp_model;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_d;

    //              stall iv  id     ordy irdy ovld odata  occ bp fd
    vecs[0]  = mk(SN, 1, 16'hA1, 1, 1, 0, 16'h00, 0, 0, 0);
    vecs[1]  = mk(SN, 0, 16'h00, 1, 1, 1, 16'hA1, 1, 0, 0);
    vecs[2]  = mk(SN, 1, 16'h01, 0, 1, 0, 16'hA1, 0, 0, 0);
    vecs[3]  = mk(SN, 1, 16'h02, 0, 1, 1, 16'h01, 1, 0, 0);
    vecs[4]  = mk(SN, 1, 16'h03, 0, 0, 1, 16'h01, 2, 1, 0);
    vecs[5]  = mk(SN, 0, 16'h00, 1, 0, 1, 16'h01, 2, 2, 0);
    vecs[6]  = mk(SN, 0, 16'h00, 1, 1, 1, 16'h02, 1, 2, 0);
    vecs[7]  = mk(SN, 1, 16'h55, 0, 1, 0, 16'h02, 0, 2, 0);
    vecs[8]  = mk(SK, 1, 16'h66, 1, 0, 0, 16'h55, 1, 2, 0);
    vecs[9]  = mk(SK, 1, 16'h66, 1, 0, 0, 16'h55, 1, 2, 0);
    vecs[10] = mk(SK, 1, 16'h66, 1, 0, 0, 16'h55, 1, 2, 0);
    vecs[11] = mk(SN, 1, 16'h66, 1, 1, 1, 16'h55, 1, 2, 0);
    vecs[12] = mk(SN, 1, 16'h77, 0, 1, 1, 16'h66, 1, 2, 0);
    vecs[13] = mk(SZ, 1, 16'h88, 1, 0, 1, 16'h66, 2, 3, 0);
    vecs[14] = mk(SN, 0, 16'h00, 0, 1, 0, 16'h00, 0, 3, 1);
    vecs[15] = mk(SN, 1, 16'h12, 0, 1, 0, 16'h00, 0, 3, 1);
    vecs[16] = mk(SU, 1, 16'h34, 0, 1, 1, 16'h12, 1, 3, 1);
    vecs[17] = mk(SZ, 1, 16'h9A, 0, 1, 0, 16'h00, 0, 4, 2);
    vecs[18] = mk(SZ, 0, 16'h00, 0, 1, 0, 16'h00, 0, 4, 3);
    vecs[19] = mk(SN, 0, 16'h00, 0, 1, 0, 16'h00, 0, 4, 3);

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stat_bp", stat_backpressure, 0);
    check("rst_stat_fd", stat_flush_drop, 0);
    step();

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      stall = vecs[i].stall; in_valid = vecs[i].iv;
      in_data = vecs[i].id; out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_irdy);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ovld);
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_odata);
      check($sformatf("v%0d_occupancy", i), occupancy, vecs[i].e_occ);
      check($sformatf("v%0d_stat_bp", i), stat_backpressure, stat_exp(vecs[i].e_bp));
      check($sformatf("v%0d_stat_fd", i), stat_flush_drop, stat_exp(vecs[i].e_fd));
      step();
    end

    // Reset with two entries held, while KEEP and handshakes are active
    do_reset();
    stall = SN; in_valid = 1'b1; in_data = 16'hB1; out_ready = 1'b0;
    step();
    in_data = 16'hB2;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("full_occupancy", occupancy, 2);
    check("full_stat_bp", stat_backpressure, stat_exp(1));
    step();
    rst = 1'b1; stall = SK; in_valid = 1'b1; in_data = 16'hCC; out_ready = 1'b1;
    step();
    rst = 1'b0; stall = SN; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("midrst_occupancy", occupancy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_stat_bp", stat_backpressure, 0);
    check("midrst_stat_fd", stat_flush_drop, 0);
    step();

    // Random handshakes with scoreboard; last cycles drain the pipe
    do_reset();
    rand_err = 0;
    bp_model = 0;
    for (int c = 0; c < 10006; c++) begin
      stall = SN;
      if (c < 10000) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_data   = DW'($urandom);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (occupancy > 2'd2 || (occupancy != 2'd0 && !out_valid) ||
          (occupancy == 2'd0 && out_valid)) begin
        if (rand_err < 5) $display("rand cycle %0d: bad occupancy %0d with out_valid %0b", c, occupancy, out_valid);
        rand_err++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          if (rand_err < 5) $display("rand cycle %0d: output %0h with nothing expected", c, out_data);
          rand_err++;
        end else begin
          exp_d = sb.pop_front();
          if (out_data !== exp_d) begin
            if (rand_err < 5) $display("rand cycle %0d: got %0h expected %0h", c, out_data, exp_d);
            rand_err++;
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && !out_ready) bp_model++;
      step();
    end
    @(negedge clk);
    check("rand_errors", 64'(rand_err), 0);
    check("rand_drained", 64'(sb.size()), 0);
    check("rand_stat_bp", stat_backpressure, stat_exp(bp_model));
    check("rand_stat_fd", stat_flush_drop, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
